ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the instruction register/decode stage.
- Keeps its own fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Branch/jump redirects flush the FIFO and restart fetch at the new target.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h0, fetch PC loaded on reset

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  reset, asynchronous, active-high
redirect_valid  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
imem_req  out  1  read request to instruction memory
imem_addr  out  32  word address of request; bits [1:0] always 0
imem_ack  in  1  memory returns imem_rdata this cycle for the current request
imem_rdata  in  32  instruction word
ins_valid  out  1  head entry valid for decode
ins_ready  in  1  decode accepts head when ins_valid=1
INSTRUCTION  out  32  head instruction word
ins_pc  out  32  PC of head instruction
q_count  out  3  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async, immediate) values:
  - imem_req=0, imem_addr=RESET_PC
  - ins_valid=0, INSTRUCTION=0, ins_pc=0, q_count=0
  - state=IDLE, fpc=RESET_PC
  - all FIFO storage cleared.
- Request protocol:
  - At most one outstanding request.
  - imem_req and imem_addr are registered outputs driven only in states REQ and DROP.
  - Address is held stable until the ack cycle; the request completes at the posedge where imem_req=1 and imem_ack=1.
  - imem_ack while imem_req=0 is ignored.
- State machine:
  - IDLE:
    - redirect → fpc=redirect_pc, remain IDLE.
    - else if q_count<DEPTH → REQ, imem_addr=fpc.
  - REQ, no ack:
    - redirect → flush, fpc=redirect_pc, DROP.
    - else remain REQ.
  - REQ, ack, no redirect:
    - push {fpc, imem_rdata}; fpc+=4.
    - If the resulting count (after any same-cycle pop) <DEPTH, stay REQ with imem_addr=fpc+4 (back-to-back, 1 word/cycle); else IDLE.
  - REQ, ack, redirect:
    - data discarded, flush, fpc=redirect_pc.
    - Go to REQ with imem_addr=redirect_pc (queue now empty).
  - DROP:
    - imem_req held with old address until ack; returned data discarded.
    - Then REQ with imem_addr=fpc.
    - Further redirects in DROP update fpc only.
- FIFO:
  - ins_valid = (q_count!=0).
  - INSTRUCTION/ins_pc are combinational reads of head storage.
  - Data pushed at edge N is visible after edge N.
  - Pop on ins_valid & ins_ready.
  - Push and pop in the same cycle leaves q_count unchanged.
  - Push is never attempted when full, because issue requires space and only one request is outstanding.
  - Flush (redirect) overrides same-cycle push/pop: q_count=0 after the edge.
- Arithmetic:
  - fpc+4 is modulo 2^32 (0xFFFFFFFC → 0x0).
  - Read/write pointers wrap modulo DEPTH.

Decomposition:
- Package mips_fetch_pkg holds:
  - fetch state encoding (IDLE, REQ, DROP)
  - WORD_W=32, PC_INC=32'd4
  - NOP_INS=32'h0
- One sub-module, ifetch_fifo: DEPTH x 64-bit {pc,ins} storage with push/pop/flush and count output, async reset.

Test Plan:
1. Reset release, imem_ack=1 every REQ cycle, rdata(0)=32'h00011020, rdata(4)=32'h00642824, rdata(8)=32'h01274025, ins_ready=1 -> imem_req high 1 cycle after reset release; ins_pc sequence 0,4,8 with the matching INSTRUCTION, one per cycle after the first.
2. ins_ready=0, zero-wait memory -> queue fills with PCs 0,4,8,12; q_count=4; imem_req=0. Raise ins_ready -> requests resume at imem_addr=0x10 and pops deliver 0x0 first.
3. Ack delayed 3 cycles on request to 0x8; redirect_pc=0x30 pulsed in the first wait cycle -> imem_req stays high at 0x8 until ack; that data is dropped; next request is 0x30; first delivered ins_pc=0x30.
4. Redirect_pc=0x30 in the same cycle as ack and pop with q_count=2 -> next cycle q_count=0, ins_valid=0, imem_addr=0x30.
5. redirect_pc=0x33 -> imem_addr=0x30. RESET_PC=32'hFFFFFFFC -> second request address is 0x0.
6. RESET pulsed between clock edges while in REQ with q_count=3 -> imem_req=0 and q_count=0 immediately; a late imem_ack is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
// Contents:
//   fetch_state_e : fetch sequencer states (IDLE, REQ, DROP)
//   WORD_W        : instruction / address word width
//   PC_INC        : byte distance between sequential instructions
//   NOP_INS       : value held in empty FIFO storage
//   word_align()  : clears the byte-offset bits of an address
package mips_fetch_pkg;

    localparam int          WORD_W  = 32;
    localparam logic [31:0] PC_INC  = 32'd4;
    localparam logic [31:0] NOP_INS = 32'h0;

    // IDLE: no request in flight. REQ: a request whose data will be kept.
    // DROP: a request issued before a redirect, so its data is thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Circular buffer of {pc, instruction} pairs feeding the decode stage.
// Ports:
//   clk, rst           : clock and asynchronous active-high reset
//   push, push_pc/ins  : write one entry at the tail
//   pop                : drop the head entry
//   flush              : empty the buffer; overrides push and pop
//   head_pc, head_ins  : combinational view of the head entry
//   count              : current occupancy, 0..DEPTH
module ifetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_pc,
    input  logic [WORD_W-1:0] push_ins,
    input  logic              pop,
    input  logic              flush,
    output logic [WORD_W-1:0] head_pc,
    output logic [WORD_W-1:0] head_ins,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [2*WORD_W-1:0] mem_q [DEPTH];
    logic [2*WORD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Next-state for storage, pointers and occupancy. Pointers wrap
    // naturally because DEPTH is a power of two. A flush only rewinds the
    // pointers; stale storage is never visible because count goes to zero.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {push_pc, push_ins};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears every entry so the head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {32'h0, NOP_INS};
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_pc  = mem_q[rd_ptr_q][2*WORD_W-1:WORD_W];
    assign head_ins = mem_q[rd_ptr_q][WORD_W-1:0];
    assign count    = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: walks a fetch PC, reads words from instruction
// memory one request at a time, queues {pc, word} pairs and hands them to
// decode. A redirect empties the queue and restarts fetch at the target.
// Ports:
//   CLK, RESET                       : clock, async active-high reset
//   redirect_valid, redirect_pc      : flush and restart fetch at target
//   imem_req, imem_addr              : registered read request to memory
//   imem_ack, imem_rdata             : memory completion and data
//   ins_valid, ins_ready             : decode handshake on the queue head
//   INSTRUCTION, ins_pc              : head instruction word and its PC
//   q_count                          : queue occupancy
module ifetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [WORD_W-1:0] INSTRUCTION,
    output logic [WORD_W-1:0] ins_pc,
    output logic [2:0]        q_count
);

    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] fpc_q, fpc_d;
    logic              imem_req_q, imem_req_d;
    logic [WORD_W-1:0] imem_addr_q, imem_addr_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_after_push;
    logic [WORD_W-1:0] target_pc;
    logic              push;
    logic              pop;

    assign target_pc = word_align(redirect_pc);
    assign ins_valid = (fifo_count != '0);
    assign pop       = ins_valid & ins_ready;

    // Occupancy the queue will have after this cycle's push and any pop;
    // decides whether the next word can be requested back-to-back.
    assign count_after_push = fifo_count + 1'b1 - CNT_W'(pop);

    // Fetch sequencer. In REQ the fetch PC always equals the address in
    // flight, so a completed request pushes fpc and advances it by one word.
    // A redirect while a request is still waiting cannot cancel it on the
    // bus, hence DROP holds the old address until the ack and discards it.
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                imem_req_d = 1'b0;
                if (redirect_valid) begin
                    fpc_d = target_pc;
                end else if (fifo_count < FULL_CNT) begin
                    state_d     = REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = fpc_q;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        fpc_d       = target_pc;
                        imem_addr_d = target_pc;
                    end else begin
                        push  = 1'b1;
                        fpc_d = fpc_q + PC_INC;
                        if (count_after_push < FULL_CNT) begin
                            imem_addr_d = fpc_q + PC_INC;
                        end else begin
                            state_d    = IDLE;
                            imem_req_d = 1'b0;
                        end
                    end
                end else if (redirect_valid) begin
                    fpc_d   = target_pc;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    fpc_d = target_pc;
                end
                if (imem_ack) begin
                    state_d     = REQ;
                    imem_addr_d = fpc_d;
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // Sequencer and request registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            fpc_q       <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RESET),
        .push     (push),
        .push_pc  (fpc_q),
        .push_ins (imem_rdata),
        .pop      (pop),
        .flush    (redirect_valid),
        .head_pc  (ins_pc),
        .head_ins (INSTRUCTION),
        .count    (fifo_count)
    );

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign q_count   = 3'(fifo_count);

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue. Two instances share all inputs: the main one
// uses RESET_PC=0, the second RESET_PC=0xFFFFFFFC to exercise PC wrap.
// Per-cycle vectors give handshake/occupancy expectations; a scoreboard
// predicts every {pc, instruction} that decode should see.
module tb_ifetch_queue;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] INSTRUCTION;
    logic [31:0] ins_pc;
    logic [2:0]  q_count;

    logic        alt_req;
    logic [31:0] alt_addr;
    logic        alt_valid;
    logic [31:0] alt_ins;
    logic [31:0] alt_pc;
    logic [2:0]  alt_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .INSTRUCTION    (INSTRUCTION),
        .ins_pc         (ins_pc),
        .q_count        (q_count)
    );

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK            (CLK),
        .RESET          (RESET),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (alt_req),
        .imem_addr      (alt_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ins_valid      (alt_valid),
        .ins_ready      (ins_ready),
        .INSTRUCTION    (alt_ins),
        .ins_pc         (alt_pc),
        .q_count        (alt_count)
    );

    typedef struct {
        bit          rst;
        int          ack_mode;
        bit          ready;
        bit          redir;
        logic [31:0] rpc;
        bit          exp_req;
        bit          chk_addr;
        logic [31:0] exp_addr;
        int          exp_cnt;
        bit          chk_alt;
        logic [31:0] exp_alt_addr;
        bit          chk_alt_head;
        logic [31:0] exp_alt_pc;
        logic [31:0] exp_alt_ins;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    vec_t        vecs[$];
    entry_t      sb[$];
    logic [31:0] exp_fpc;
    bit          drop_pending;

    // Instruction memory contents: three fixed words, then address-derived.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0001_1020;
            32'h4:   return 32'h0064_2824;
            32'h8:   return 32'h0127_4025;
            default: return {a[15:0], 16'hC0DE} ^ 32'h1357_0000;
        endcase
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input bit exp_req, input bit chk_addr,
                               input logic [31:0] exp_addr, input int exp_cnt);
        checkVal("imem_req", imem_req, exp_req);
        if (chk_addr) checkVal("imem_addr", imem_addr, exp_addr);
        checkVal("q_count", q_count, exp_cnt);
        checkVal("ins_valid", ins_valid, exp_cnt != 0);
    endtask

    task automatic resetDut();
        RESET          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        ins_ready      = 1'b0;
        sb.delete();
        exp_fpc      = 32'h0;
        drop_pending = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // ack_mode: 0 no ack, 1 ack when a request is up, 2 ack unconditionally.
    task automatic applyStimulus(input int ack_mode, input bit ready,
                                 input bit redir, input logic [31:0] rpc);
        logic ack;
        ack = (ack_mode == 2) || (ack_mode == 1 && imem_req);
        ins_ready      = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_ack       = ack;
        imem_rdata     = memWord(imem_addr);

        if (imem_req && !drop_pending) checkVal("imem_addr_vs_fpc", imem_addr, exp_fpc);
        checkVal("ins_valid_vs_sb", ins_valid, sb.size() != 0);
        if (ins_valid && sb.size() != 0) begin
            checkVal("ins_pc", ins_pc, sb[0].pc);
            checkVal("INSTRUCTION", INSTRUCTION, sb[0].ins);
        end

        if (redir) begin
            sb.delete();
            exp_fpc = rpc & 32'hFFFF_FFFC;
            if (imem_req) drop_pending = !ack;
        end else begin
            if (ins_valid && ready && sb.size() != 0) void'(sb.pop_front());
            if (imem_req && ack) begin
                if (drop_pending) begin
                    drop_pending = 1'b0;
                end else begin
                    sb.push_back({exp_fpc, memWord(exp_fpc)});
                    exp_fpc = exp_fpc + 32'd4;
                end
            end
        end

        @(posedge CLK);
        #1;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        @(negedge CLK);
    endtask

    task automatic addVec(input bit rst, input int am, input bit rdy, input bit rd,
                          input logic [31:0] rpc, input bit er, input bit ca,
                          input logic [31:0] ea, input int ec, input bit calt,
                          input logic [31:0] ealt, input bit ch,
                          input logic [31:0] hpc, input logic [31:0] hins);
        vec_t v;
        v = '{rst, am, rdy, rd, rpc, er, ca, ea, ec, calt, ealt, ch, hpc, hins};
        vecs.push_back(v);
    endtask

    initial begin
        // Streaming with ready=1; wrap instance checked in the first cycles.
        addVec(1, 1, 1, 0, 32'h0, 0, 1, 32'h0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
        addVec(0, 1, 1, 0, 32'h0, 1, 1, 32'h0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
        addVec(0, 1, 1, 0, 32'h0, 1, 1, 32'h4, 1, 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h0001_1020);
        addVec(0, 1, 1, 0, 32'h0, 1, 1, 32'h8, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 1, 1, 0, 32'h0, 1, 1, 32'hC, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        // Fill with decode stalled, then drain and resume.
        addVec(1, 1, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 1, 0, 0, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 1, 0, 0, 32'h0, 1, 1, 32'h4, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 1, 0, 0, 32'h0, 1, 1, 32'h8, 2, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 1, 0, 0, 32'h0, 1, 1, 32'hC, 3, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 4, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 1, 1, 0, 32'h0, 0, 0, 32'h0, 4, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 1, 1, 0, 32'h0, 0, 0, 32'h0, 3, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 1, 1, 0, 32'h0, 1, 1, 32'h10, 2, 0, 32'h0, 0, 32'h0, 32'h0);
        // Redirect coinciding with ack and pop at q_count=2.
        addVec(0, 1, 1, 1, 32'h30, 1, 1, 32'h14, 2, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 1, 1, 0, 32'h0, 1, 1, 32'h30, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        // Misaligned redirect target is forced to a word address.
        addVec(0, 1, 1, 1, 32'h33, 1, 1, 32'h34, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 1, 1, 0, 32'h0, 1, 1, 32'h30, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        addVec(0, 0, 1, 0, 32'h0, 1, 1, 32'h34, 1, 0, 32'h0, 0, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) resetDut();
            checkOutput(vecs[i].exp_req, vecs[i].chk_addr, vecs[i].exp_addr, vecs[i].exp_cnt);
            if (vecs[i].chk_alt) checkVal("wrap_imem_addr", alt_addr, vecs[i].exp_alt_addr);
            if (vecs[i].chk_alt_head) begin
                checkVal("wrap_ins_valid", alt_valid, 1);
                checkVal("wrap_ins_pc", alt_pc, vecs[i].exp_alt_pc);
                checkVal("wrap_INSTRUCTION", alt_ins, vecs[i].exp_alt_ins);
            end
            applyStimulus(vecs[i].ack_mode, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
        end
        checkVal("sb_drained", sb.size(), 0);

        // Redirect while the request to 0x8 waits for a slow ack.
        resetDut();
        checkOutput(0, 1, 32'h0, 0);  applyStimulus(1, 1, 0, 32'h0);
        checkOutput(1, 1, 32'h0, 0);  applyStimulus(1, 1, 0, 32'h0);
        checkOutput(1, 1, 32'h4, 1);  applyStimulus(1, 1, 0, 32'h0);
        checkOutput(1, 1, 32'h8, 1);  applyStimulus(0, 1, 1, 32'h30);
        checkOutput(1, 1, 32'h8, 0);  applyStimulus(0, 1, 0, 32'h0);
        checkOutput(1, 1, 32'h8, 0);  applyStimulus(0, 1, 0, 32'h0);
        checkOutput(1, 1, 32'h8, 0);  applyStimulus(1, 1, 0, 32'h0);
        checkOutput(1, 1, 32'h30, 0); applyStimulus(1, 1, 0, 32'h0);
        checkOutput(1, 1, 32'h34, 1); applyStimulus(0, 1, 0, 32'h0);
        checkOutput(1, 1, 32'h34, 0);

        // Asynchronous reset mid-cycle in REQ with three entries queued.
        resetDut();
        checkOutput(0, 1, 32'h0, 0);  applyStimulus(1, 0, 0, 32'h0);
        checkOutput(1, 1, 32'h0, 0);  applyStimulus(1, 0, 0, 32'h0);
        checkOutput(1, 1, 32'h4, 1);  applyStimulus(1, 0, 0, 32'h0);
        checkOutput(1, 1, 32'h8, 2);  applyStimulus(1, 0, 0, 32'h0);
        checkOutput(1, 1, 32'hC, 3);
        RESET = 1'b1;
        #1;
        checkVal("async_imem_req", imem_req, 0);
        checkVal("async_q_count", q_count, 0);
        checkVal("async_ins_valid", ins_valid, 0);
        checkVal("async_imem_addr", imem_addr, 32'h0);
        checkVal("async_ins_pc", ins_pc, 32'h0);
        checkVal("async_INSTRUCTION", INSTRUCTION, 32'h0);
        checkVal("async_wrap_req", alt_req, 0);
        checkVal("async_wrap_count", alt_count, 0);
        checkVal("async_wrap_addr", alt_addr, 32'hFFFF_FFFC);
        sb.delete();
        exp_fpc      = 32'h0;
        drop_pending = 1'b0;
        #1;
        RESET = 1'b0;
        applyStimulus(2, 1, 0, 32'h0);
        checkOutput(1, 1, 32'h0, 0);  applyStimulus(1, 1, 0, 32'h0);
        checkOutput(1, 1, 32'h4, 1);  applyStimulus(0, 1, 0, 32'h0);
        checkOutput(1, 1, 32'h4, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
